ring_seq_counter: RTL

RING_SEQ_COUNTER -- requirements
Module: ring_seq_counter

---
 rtl/ring_seq_counter_pkg.sv | 11 +
 rtl/ring_seq_counter_if.sv | 25 ++
 rtl/ring_pattern_chk.sv | 28 ++
 rtl/ring_seq_counter.sv | 82 ++++++++
 4 files changed

// File: rtl/ring_seq_counter_pkg.sv
// Shared types and constants for the ring/Johnson sequence counter.
package ring_seq_counter_pkg;

    localparam int RING_WIDTH = 4;

    typedef enum logic {
        RING_ONEHOT  = 1'b0,
        RING_JOHNSON = 1'b1
    } ring_mode_e;

endpackage

// File: rtl/ring_seq_counter_if.sv
// Control/status bundle between a driver and the sequence counter.
interface ring_seq_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic             valid;
    logic             mode_q;
    logic             wrap;
    logic             load_err;

    modport master (
        output load, mode, data_in, en, dir,
        input  count, valid, mode_q, wrap, load_err
    );

    modport slave (
        input  load, mode, data_in, en, dir,
        output count, valid, mode_q, wrap, load_err
    );
endinterface

// File: rtl/ring_pattern_chk.sv
// Combinational legality check of a load pattern for the selected mode.
module ring_pattern_chk
    import ring_seq_counter_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH
) (
    input  ring_mode_e       mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             legal
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] inv;
    logic             onehot;
    logic             thermo_lo;
    logic             thermo_hi;

    // x & (x+1) == 0 holds exactly for ones packed from the LSB
    always_comb begin
        inv       = ~data_in;
        onehot    = (data_in != '0) && ((data_in & (data_in - ONE)) == '0);
        thermo_lo = ((data_in & (data_in + ONE)) == '0);
        thermo_hi = ((inv & (inv + ONE)) == '0);
        legal     = (mode == RING_JOHNSON) ? (thermo_lo || thermo_hi) : onehot;
    end

endmodule

// File: rtl/ring_seq_counter.sv
// One-hot / Johnson ring counter with checked load, direction and wrap pulse.
module ring_seq_counter
    import ring_seq_counter_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH
) (
    input logic               clk,
    input logic               reset,
    ring_seq_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    ring_mode_e       mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] step;
    logic             step_wrap;
    logic             legal;

    ring_pattern_chk #(.WIDTH(WIDTH)) u_chk (
        .mode    (ring_mode_e'(bus.mode)),
        .data_in (bus.data_in),
        .legal   (legal)
    );

    always_comb begin
        if (mode_q == RING_ONEHOT) begin
            step      = bus.dir ? {count_q[0], count_q[WIDTH-1:1]}
                                : {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            step_wrap = bus.dir ? count_q[0] : count_q[WIDTH-1];
        end else begin
            step      = bus.dir ? {~count_q[0], count_q[WIDTH-1:1]}
                                : {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            step_wrap = bus.dir ? (count_q == '0) : (step == '0);
        end
    end

    always_comb begin
        count_d    = count_q;
        valid_d    = valid_q;
        mode_d     = mode_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (legal) begin
                count_d = bus.data_in;
                mode_d  = ring_mode_e'(bus.mode);
                valid_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en && valid_q) begin
            count_d = step;
            wrap_d  = step_wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            valid_q    <= 1'b0;
            mode_q     <= RING_ONEHOT;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            valid_q    <= valid_d;
            mode_q     <= mode_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.valid    = valid_q;
    assign bus.mode_q   = mode_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule
